// File: rtl/sram_march_bist_pkg.sv
// March C- element/op definitions shared by the BIST engine and its read checker.
package sram_march_bist_pkg;

  typedef enum logic [2:0] {
    ELEM_E0 = 3'd0, ELEM_E1 = 3'd1, ELEM_E2 = 3'd2,
    ELEM_E3 = 3'd3, ELEM_E4 = 3'd4, ELEM_E5 = 3'd5
  } march_elem_e;

  // Element states share their low 3 bits with march_elem_e.
  typedef enum logic [3:0] {
    ST_E0 = 4'd0, ST_E1 = 4'd1, ST_E2 = 4'd2, ST_E3 = 4'd3, ST_E4 = 4'd4, ST_E5 = 4'd5,
    ST_IDLE = 4'd6, ST_DRAIN = 4'd7, ST_DONE = 4'd8
  } bist_state_e;

  typedef struct packed {
    logic we;
    logic pattern_one;
    logic ascending;
  } march_op_t;

  function automatic logic [1:0] march_num_ops(march_elem_e e);
    return (e == ELEM_E0 || e == ELEM_E5) ? 2'd1 : 2'd2;
  endfunction

  // Two-op elements are always read-then-write with opposite patterns.
  function automatic march_op_t march_op(march_elem_e e, logic op_idx);
    march_op_t op;
    op.we          = 1'b0;
    op.pattern_one = 1'b0;
    op.ascending   = !(e == ELEM_E3 || e == ELEM_E4);
    case (e)
      ELEM_E0: op.we = 1'b1;
      ELEM_E1, ELEM_E3: begin
        op.we          = op_idx;
        op.pattern_one = op_idx;
      end
      ELEM_E2, ELEM_E4: begin
        op.we          = op_idx;
        op.pattern_one = !op_idx;
      end
      default: op.we = 1'b0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sram_march_bist_chk.sv
// Read-data checker: Latency-deep expected-data pipe, comparator,
// saturating error counter and first-failure capture.
module sram_march_bist_chk import sram_march_bist_pkg::*; #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 10,
  parameter int Latency     = 1,
  parameter int ErrCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_vld_i,
  input  logic                   push_one_i,
  input  logic [AddrWidth-1:0]   push_addr_i,
  input  march_elem_e            push_elem_i,
  input  logic [DataWidth-1:0]   rdata_i,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [AddrWidth-1:0]   fail_addr_o,
  output logic [2:0]             fail_elem_o
);

  logic [Latency-1:0]                vld_pipe, one_pipe;
  logic [Latency-1:0][AddrWidth-1:0] addr_pipe;
  logic [Latency-1:0][2:0]           elem_pipe;

  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]             fail_elem_q, fail_elem_d;
  logic [DataWidth-1:0]   exp_data;
  logic                   mismatch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe  <= '0;
      one_pipe  <= '0;
      addr_pipe <= '0;
      elem_pipe <= '0;
    end else begin
      vld_pipe[0]  <= push_vld_i;
      one_pipe[0]  <= push_one_i;
      addr_pipe[0] <= push_addr_i;
      elem_pipe[0] <= push_elem_i;
      for (int i = 1; i < Latency; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        one_pipe[i]  <= one_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
        elem_pipe[i] <= elem_pipe[i-1];
      end
    end
  end

  assign exp_data = {DataWidth{one_pipe[Latency-1]}};
  assign mismatch = vld_pipe[Latency-1] && (rdata_i != exp_data);

  // A zero count means no mismatch yet, so it doubles as the first-fail flag.
  always_comb begin
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (clr_i) begin
      err_cnt_d   = '0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch) begin
      if (err_cnt_q == '0) begin
        fail_addr_d = addr_pipe[Latency-1];
        fail_elem_d = elem_pipe[Latency-1];
      end
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign err_cnt_o   = err_cnt_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for one SRAM port: sequencing FSM, address/op
// counters and SRAM drive; read checking lives in sram_march_bist_chk.
module sram_march_bist import sram_march_bist_pkg::*; #(
  parameter  int NumWords    = 1024,
  parameter  int DataWidth   = 64,
  parameter  int ByteWidth   = 8,
  parameter  int Latency     = 1,
  parameter  int ErrCntWidth = 16,
  parameter  int AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [AddrWidth-1:0]   fail_addr_o,
  output logic [2:0]             fail_elem_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic                   req_o,
  output logic                   we_o,
  output logic [AddrWidth-1:0]   addr_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [BeWidth-1:0]     be_o,
  input  logic [DataWidth-1:0]   rdata_i
);

  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "sram_march_bist: Latency must be >= 1");
  end
  if (NumWords < 2) begin : g_bad_depth
    $fatal(1, "sram_march_bist: NumWords must be >= 2");
  end

  localparam int DrainW = (Latency > 1) ? $clog2(Latency) : 1;

  bist_state_e          state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 op_q, op_d;
  logic [DrainW-1:0]    drain_q, drain_d;

  logic        in_elem, start_acc, last_op, last_addr;
  march_elem_e cur_elem, nxt_elem;
  march_op_t   cur_op;

  assign in_elem   = (state_q <= ST_E5);
  assign cur_elem  = march_elem_e'(state_q[2:0]);
  assign nxt_elem  = march_elem_e'(state_q[2:0] + 3'd1);
  assign cur_op    = march_op(cur_elem, op_q);
  assign last_op   = (march_num_ops(cur_elem) == 2'd1) || op_q;
  assign last_addr = cur_op.ascending ? (addr_q == AddrWidth'(NumWords - 1)) : (addr_q == '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    drain_d   = drain_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = ST_E0;
          addr_d    = '0;
          op_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DrainW'(Latency - 1)) state_d = ST_DONE;
        else                                  drain_d = drain_q + 1'b1;
      end
      default: begin
        if (!in_elem) begin
          state_d = ST_IDLE;
        end else if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!last_addr) begin
            addr_d = cur_op.ascending ? addr_q + 1'b1 : addr_q - 1'b1;
          end else if (cur_elem == ELEM_E5) begin
            state_d = ST_DRAIN;
            drain_d = '0;
            addr_d  = '0;
          end else begin
            // Address wrap: next element starts at its own first address.
            state_d = bist_state_e'({1'b0, nxt_elem});
            addr_d  = march_op(nxt_elem, 1'b0).ascending ? '0 : AddrWidth'(NumWords - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      op_q    <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      drain_q <= drain_d;
    end
  end

  assign busy_o  = in_elem || (state_q == ST_DRAIN);
  assign done_o  = (state_q == ST_DONE);
  assign pass_o  = done_o && (err_cnt_o == '0);
  assign req_o   = in_elem;
  assign we_o    = in_elem && cur_op.we;
  assign addr_o  = in_elem ? addr_q : '0;
  assign wdata_o = {DataWidth{we_o && cur_op.pattern_one}};
  assign be_o    = {BeWidth{in_elem}};

  sram_march_bist_chk #(
    .DataWidth  (DataWidth),
    .AddrWidth  (AddrWidth),
    .Latency    (Latency),
    .ErrCntWidth(ErrCntWidth)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (start_acc),
    .push_vld_i (in_elem && !cur_op.we),
    .push_one_i (cur_op.pattern_one),
    .push_addr_i(addr_q),
    .push_elem_i(cur_elem),
    .rdata_i    (rdata_i),
    .err_cnt_o  (err_cnt_o),
    .fail_addr_o(fail_addr_o),
    .fail_elem_o(fail_elem_o)
  );

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench: two BIST instances (4 words/lat 1/16-bit count, 8 words/lat 3/2-bit count)
// against cycle-level SRAM models with injectable faults and an abstract March C- model.
module tb_sram_march_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          we;
    int          addr;
    logic [63:0] data;
  } op_t;

  logic [1:0] rst_a = 2'b00, start_a = 2'b00;
  logic [1:0] done_w, busy_w, req_w;
  bit sa_en[2], sa_val[2], corrupt[2];
  int sa_addr[2], sa_bit[2];

  // Stuck-at cell fault applied on write.
  function automatic logic [63:0] flt(input int i, input int a, input logic [63:0] d);
    logic [63:0] r;
    r = d;
    if (sa_en[i] && a == sa_addr[i]) r[sa_bit[i]] = sa_val[i];
    return r;
  endfunction

  function automatic int nw_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int done_cyc(input int i);
    return 10 * nw_of(i) + ((i == 0) ? 1 : 3) + 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int NW  = (g == 0) ? 4 : 8;
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int ECW = (g == 0) ? 16 : 2;
    localparam int AW  = $clog2(NW);

    logic rst_n, start, busy, done, pass, req, we;
    logic [AW-1:0]  fail_addr, addr;
    logic [2:0]     fail_elem;
    logic [ECW-1:0] err_cnt;
    logic [63:0]    wdata, rdata;
    logic [7:0]     be;

    assign rst_n     = rst_a[g];
    assign start     = start_a[g];
    assign done_w[g] = done;
    assign busy_w[g] = busy;
    assign req_w[g]  = req;

    sram_march_bist #(
      .NumWords(NW), .DataWidth(64), .ByteWidth(8), .Latency(LAT), .ErrCntWidth(ECW)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
      .pass_o(pass), .fail_addr_o(fail_addr), .fail_elem_o(fail_elem), .err_cnt_o(err_cnt),
      .req_o(req), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be), .rdata_i(rdata)
    );

    // SRAM: junk on rdata whenever no read is due.
    logic [63:0] mem [NW];
    logic [63:0] rpipe [LAT];
    always @(posedge clk) begin
      if (req && we) mem[addr] <= flt(g, int'(addr), wdata);
      rpipe[0] <= (req && !we) ? (mem[addr] ^ {64{corrupt[g]}}) : {$urandom, $urandom};
      for (int s = 1; s < LAT; s++) rpipe[s] <= rpipe[s-1];
    end
    assign rdata = rpipe[LAT-1];

    op_t ops[$];
    bit  m_act, m_done;
    int  cyc, e_err, e_faddr, e_felem;

    // Abstract March C-: each element reads back what the previous one wrote.
    task automatic build();
      logic [63:0] m [NW];
      logic [63:0] want, got, wd;
      int nerr;
      nerr = 0;
      ops.delete();
      e_faddr = 0;
      e_felem = 0;
      for (int e = 0; e < 6; e++) begin
        for (int k = 0; k < NW; k++) begin
          int a;
          a = (e == 3 || e == 4) ? NW - 1 - k : k;
          if (e != 0) begin
            want = (e == 2 || e == 4) ? '1 : '0;
            got  = m[a] ^ {64{corrupt[g]}};
            ops.push_back('{1'b0, a, 64'd0});
            if (got != want) begin
              nerr++;
              if (nerr == 1) begin e_faddr = a; e_felem = e; end
            end
          end
          if (e != 5) begin
            wd = (e == 1 || e == 3) ? '1 : '0;
            ops.push_back('{1'b1, a, wd});
            m[a] = flt(g, a, wd);
          end
        end
      end
      e_err = (nerr > (2 ** ECW) - 1) ? (2 ** ECW) - 1 : nerr;
    endtask

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_act  <= 1'b0;
        m_done <= 1'b0;
        cyc    <= 0;
      end else if (!m_act && start) begin
        build();
        m_act  <= 1'b1;
        m_done <= 1'b0;
        cyc    <= 1;
      end else if (m_act) begin
        if (cyc == 10 * NW + LAT) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end
        cyc <= cyc + 1;
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        check("rst_ctrl", 64'({busy, done, pass, req, we}), 64'd0);
        check("rst_bus", 64'(|{addr, wdata, be, fail_addr, fail_elem, err_cnt}), 64'd0);
      end else begin
        check("busy", 64'(busy), 64'(m_act));
        check("done", 64'(done), 64'(m_done));
        if (m_act && cyc <= 10 * NW) begin
          check("bus", 64'({req, we, be, addr}),
                64'({1'b1, ops[cyc-1].we, 8'hff, AW'(ops[cyc-1].addr)}));
          if (ops[cyc-1].we) check("wdata", wdata, ops[cyc-1].data);
        end else begin
          check("req_idle", 64'(req), 64'd0);
        end
        if (m_done) begin
          check("pass", 64'(pass), 64'(e_err == 0));
          check("err_cnt", 64'(err_cnt), 64'(e_err));
          check("fail_addr", 64'(fail_addr), 64'(e_faddr));
          check("fail_elem", 64'(fail_elem), 64'(e_felem));
        end else begin
          check("pass_not_done", 64'(pass), 64'd0);
        end
        if (m_act && cyc == 1) check("start_clear", 64'({err_cnt, fail_addr, fail_elem}), 64'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_start(input int i);
    start_a[i] = 1'b1;
    step(1);
    start_a[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int n);
    n = 1;
    while (!done_w[i] && n < 3000) begin step(1); n++; end
    check("done_seen", 64'(done_w[i]), 64'd1);
  endtask

  task automatic run_one(input int i);
    int n;
    do_start(i);
    wait_done(i, n);
    check("done_cycle", 64'(n), 64'(done_cyc(i)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish by 300us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step(3);
    rst_a = 2'b11;
    step(1);

    // Fault-free, both geometries.
    run_one(0);
    run_one(1);

    // Stuck-at-0 on bit 5 of word 2.
    sa_en[0] = 1; sa_addr[0] = 2; sa_bit[0] = 5; sa_val[0] = 0;
    run_one(0);
    check("s2_fail_addr", 64'(g_i[0].fail_addr), 64'd2);
    check("s2_fail_elem", 64'(g_i[0].fail_elem), 64'd2);
    check("s2_err_cnt", 64'(g_i[0].err_cnt), 64'd2);
    check("s2_pass", 64'(g_i[0].pass), 64'd0);

    // Every read corrupted with a 2-bit counter.
    corrupt[1] = 1;
    run_one(1);
    check("s6_err_cnt", 64'(g_i[1].err_cnt), 64'd3);
    check("s6_fail_addr", 64'(g_i[1].fail_addr), 64'd0);
    check("s6_fail_elem", 64'(g_i[1].fail_elem), 64'd1);
    corrupt[1] = 0;

    // Start held high across several tests, then a pulse while busy.
    sa_en[0] = 1; sa_addr[0] = 1; sa_bit[0] = 0; sa_val[0] = 1;
    start_a[0] = 1'b1;
    step(100);
    start_a[0] = 1'b0;
    wait_done(0, n);
    do_start(0);
    step(10);
    start_a[0] = 1'b1;
    step(1);
    start_a[0] = 1'b0;
    wait_done(0, n);
    check("s4_prev_err", 64'(g_i[0].err_cnt != '0), 64'd1);
    sa_en[0] = 0;
    do_start(0);
    check("s4_restart_err", 64'(g_i[0].err_cnt), 64'd0);
    check("s4_restart_pass", 64'(g_i[0].pass), 64'd0);
    wait_done(0, n);
    check("s4_clean_pass", 64'(g_i[0].pass), 64'd1);

    // Asynchronous reset in cycle 15 of a test.
    do_start(0);
    step(14);
    rst_a[0] = 1'b0;
    #1;
    check("s5_req", 64'(req_w[0]), 64'd0);
    check("s5_busy", 64'(busy_w[0]), 64'd0);
    step(2);
    rst_a[0] = 1'b1;
    step(1);
    run_one(0);

    // Random single stuck-at faults, random idle gaps.
    for (int r = 0; r < 8; r++) begin
      int i;
      i = r % 2;
      sa_en[i]   = bit'($urandom_range(0, 1));
      sa_addr[i] = $urandom_range(0, nw_of(i) - 1);
      sa_bit[i]  = $urandom_range(0, 63);
      sa_val[i]  = bit'($urandom_range(0, 1));
      step($urandom_range(0, 3));
      run_one(i);
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
